ofm_packer: RTL
===============

OFM_PACKER -- requirements
Module: ofm_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit words held in the output FIFO (power of two, >=2).
REQ-002 Clock and reset are fixed: one clock `clk`; reset `reset_n` is asynchronous and active-low.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 OFM  input  8  accumulated result byte from the PE.
REQ-006 valid  input  1  PE one-cycle strobe: OFM is valid this cycle.
REQ-007 flush  input  1  one-cycle request to emit any partial word.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_data  output  32  packed word, FIFO head.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_bytes  output  3  count of meaningful bytes in out_data (1..4).
REQ-012 overflow  output  1  sticky: a completed word was dropped.
REQ-013 busy  output  1  partial word pending or FIFO non-empty.

Function
REQ-014 The block SHALL capture OFM on every cycle with valid=1, into byte lane k = byte counter (0..3), bits [8k+7:8k], little-endian.
REQ-015 The byte counter SHALL increment on each capture and wrap 3->0; reaching wrap completes a word with out_bytes=4.
REQ-016 A completed word SHALL be written to the FIFO at the same clock edge as the 4th capture; out_valid SHALL rise the following cycle (latency 1 from the 4th valid).
REQ-017 flush with counter>0 SHALL complete a word with out_bytes=counter, unused lanes zero, and reset the counter to 0; flush with counter=0 SHALL do nothing.
REQ-018 valid and flush in the same cycle: the byte SHALL be captured first and included in the flushed word (out_bytes=counter+1; if that is 4 it is a normal full word).
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1; out_data/out_bytes SHALL advance to the next entry the cycle after.
REQ-020 A push SHALL be accepted when FIFO not full, or when full and a pop occurs in the same cycle.
REQ-021 A push refused for fullness SHALL discard the word, set overflow=1, and still reset the byte counter.
REQ-022 out_data/out_bytes SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or occupancy counter.
REQ-024 busy SHALL equal (counter!=0) OR out_valid.

Reset
REQ-025 reset_n=0 SHALL immediately clear counter, FIFO pointers, partial-word register and overflow; out_valid=0, out_data=0, out_bytes=0, overflow=0, busy=0.
REQ-026 Reset mid-word or with FIFO non-empty SHALL discard all pending data; no word SHALL emerge after release until 4 new bytes or a flush.
REQ-027 overflow SHALL be cleared only by reset.

Configuration
REQ-028 Macro OFM_RELU_EN defined: OFM SHALL be treated as signed two's complement and bytes with bit7=1 SHALL be captured as 8'h00.
REQ-029 OFM_RELU_EN undefined: OFM SHALL be captured unmodified.

Verification
REQ-030 Bytes 11,22,33,44 on 4 consecutive valids, out_ready=1 -> next cycle out_data=32'h44332211, out_bytes=4, one-cycle out_valid.
REQ-031 Bytes AA,BB then flush (no valid) -> out_data=32'h0000BBAA, out_bytes=2; flush with counter=0 -> no output.
REQ-032 Bytes 01,02,03 then valid=1 OFM=04 with flush=1 -> single word 32'h04030201, out_bytes=4, no extra word.
REQ-033 out_ready=0, push 5 full words (FIFO_DEPTH=4) -> 4 words retained in order, overflow=1; then out_ready=1 drains exactly 4 words.
REQ-034 Reset asserted after 2 bytes and with 2 FIFO words -> out_valid=0, busy=0 immediately; after release bytes 05,06,07,08 -> 32'h08070605.
REQ-035 With OFM_RELU_EN: bytes 80,7F,FF,01 -> 32'h01007F00; without: 32'h01FF7F80.

Source files
------------

// File: rtl/ofm_packer.sv
// ofm_packer: packs PE result bytes into little-endian 32-bit words and queues them in a small FIFO.
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   OFM        result byte, captured when valid=1
//   valid      one-cycle strobe for OFM
//   flush      emit the partial word (if any) now
//   out_ready  downstream accepts the FIFO head
//   out_data   FIFO head word
//   out_valid  FIFO non-empty
//   out_bytes  meaningful bytes in out_data (1..4)
//   overflow   sticky: a completed word was dropped because the FIFO was full
//   busy       partial word pending or FIFO non-empty
// Build option: define OFM_RELU_EN to clamp negative (bit7=1) bytes to 8'h00 on capture.
module ofm_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  OFM,
    input  logic        valid,
    input  logic        flush,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic [2:0]  out_bytes,
    output logic        overflow,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] part_q, part_d, word_d;
    logic [AW:0] wptr_q, rptr_q;
    logic        overflow_q;
    logic [7:0]  byte_in;
    logic [2:0]  fill;
    logic        push, pop, wr, empty, full;
    logic [31:0] data_mem [FIFO_DEPTH];
    logic [2:0]  bytes_mem [FIFO_DEPTH];

`ifdef OFM_RELU_EN
    assign byte_in = OFM[7] ? 8'h00 : OFM;
`else
    assign byte_in = OFM;
`endif

    // The incoming byte lands in its lane before a flush looks at the word,
    // so valid+flush in one cycle emits the byte as part of the flushed word.
    always_comb begin
        word_d = part_q;
        for (int k = 0; k < 4; k++)
            if (valid && cnt_q == 2'(k)) word_d[8*k +: 8] = byte_in;
    end

    assign fill   = {1'b0, cnt_q} + {2'b0, valid};
    assign push   = (fill == 3'd4) || (flush && fill != 3'd0);
    // Counter and partial word restart on every completed word, accepted or dropped.
    assign cnt_d  = push ? 2'd0 : fill[1:0];
    assign part_d = push ? 32'd0 : word_d;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty = wptr_q == rptr_q;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && out_ready;
    assign wr    = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= 2'd0;
            part_q     <= 32'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            part_q     <= part_d;
            wptr_q     <= wr ? wptr_q + (AW+1)'(1) : wptr_q;
            rptr_q     <= pop ? rptr_q + (AW+1)'(1) : rptr_q;
            overflow_q <= overflow_q | (push && !wr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            data_mem[wptr_q[AW-1:0]]  <= word_d;
            bytes_mem[wptr_q[AW-1:0]] <= fill;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : data_mem[rptr_q[AW-1:0]];
    assign out_bytes = empty ? 3'd0 : bytes_mem[rptr_q[AW-1:0]];
    assign overflow  = overflow_q;
    assign busy      = (cnt_q != 2'd0) || !empty;
endmodule
